// File: rtl/mips_pkg.sv
// Shared arbiter types: FSM state encoding and data-port operation codes.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DATA  = 2'b01,
    FETCH = 2'b10
  } arbStateT;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE_DW = 2'b01,
    OP_WRITE_B  = 2'b10,
    OP_RSVD     = 2'b11
  } dOpT;

  localparam logic [7:0] BE_ALL = 8'hFF;

  // Reserved encoding falls through to a read.
  function automatic logic isWrite(input dOpT op);
    return (op == OP_WRITE_DW) || (op == OP_WRITE_B);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting between the latched request and the doubleword memory port.
// Latency: purely combinational.
// Backpressure: none; follows whatever the arbiter presents.
module mem_lane_fmt
  import mips_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         isFetch,
  input  logic [1:0]   op,
  input  logic [2:0]   byteOff,
  input  logic [N-1:0] wdata,
  input  logic [N-1:0] rdata,
  output logic         we,
  output logic [7:0]   be,
  output logic [N-1:0] wdataFmt,
  output logic [31:0]  fetchWord
);

  dOpT opType;
  assign opType = dOpT'(op);

  // Fetches and reads enable every lane; a byte store hits one lane with the byte replicated everywhere.
  always_comb begin
    we       = 1'b0;
    be       = BE_ALL;
    wdataFmt = wdata;
    if (!isFetch) begin
      we = isWrite(opType);
      if (opType == OP_WRITE_B) begin
        be       = 8'h01 << byteOff;
        wdataFmt = {(N/8){wdata[7:0]}};
      end
    end
  end

  // Instructions are 32 bits; address bit 2 picks the half of the doubleword.
  assign fetchWord = byteOff[2] ? rdata[N-1 -: 32] : rdata[31:0];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one doubleword memory port.
// Latency: grant on the edge sampling the request, mem_req the next cycle, ready the cycle after mem_ack or timeout.
// Backpressure: requesters hold req until their ready pulse; memory stalls by withholding mem_ack, bounded by TMO.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int N   = 64,
  parameter int W   = 32,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_ready,
  input  logic         d_req,
  input  logic [1:0]   d_op,
  input  logic [W-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [7:0]   mem_be,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         busy,
  output logic         err
);

  localparam int          CW       = $clog2(TMO + 2);
  localparam logic [31:0] TmoLimit = 32'(TMO);

  arbStateT      stateQ, stateD;
  logic [W-1:0]  latAddr;
  logic [1:0]    latOp;
  logic [N-1:0]  latWdata;
  logic [CW-1:0] tmoCnt;
  logic          lastWasData;

  logic          inAccess, grantData, grantFetch, tmoExpire;
  logic          fmtWe;
  logic [7:0]    fmtBe;
  logic [N-1:0]  fmtWdata;
  logic [31:0]   fetchWord;

  assign inAccess   = (stateQ != IDLE);
  // Data wins a tie unless the previous access was data, so fetch cannot be starved by a streaming load/store.
  assign grantData  = (stateQ == IDLE) && d_req && !(if_req && lastWasData);
  assign grantFetch = (stateQ == IDLE) && if_req && !grantData;
  // The current cycle is the TMO-th waiting cycle and the memory still has not answered.
  assign tmoExpire  = inAccess && !mem_ack &&
                      (({{(32-CW){1'b0}}, tmoCnt} + 32'd1) >= TmoLimit);

  mem_lane_fmt #(.N(N)) u_lane_fmt (
    .isFetch  (stateQ == FETCH),
    .op       (latOp),
    .byteOff  (latAddr[2:0]),
    .wdata    (latWdata),
    .rdata    (mem_rdata),
    .we       (fmtWe),
    .be       (fmtBe),
    .wdataFmt (fmtWdata),
    .fetchWord(fetchWord)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Next state: grant from IDLE, return on ack or timeout.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (grantData)       stateD = DATA;
        else if (grantFetch) stateD = FETCH;
      end
      DATA, FETCH: begin
        if (mem_ack || tmoExpire) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Memory port decodes straight from state and the latched request.
  always_comb begin
    mem_req   = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (inAccess) begin
      mem_req   = 1'b1;
      busy      = 1'b1;
      mem_we    = fmtWe;
      mem_be    = fmtBe;
      mem_addr  = {latAddr[W-1:3], 3'b000};
      mem_wdata = fmtWdata;
    end
  end

  // Request latch, timeout counter, fairness flag and registered completion outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latAddr     <= '0;
      latOp       <= OP_READ;
      latWdata    <= '0;
      tmoCnt      <= '0;
      lastWasData <= 1'b0;
      if_rdata    <= '0;
      if_ready    <= 1'b0;
      d_rdata     <= '0;
      d_ready     <= 1'b0;
      err         <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grantData) begin
        latAddr     <= d_addr;
        latOp       <= d_op;
        latWdata    <= d_wdata;
        tmoCnt      <= '0;
        lastWasData <= 1'b0;
      end else if (grantFetch) begin
        latAddr     <= if_addr;
        latOp       <= OP_READ;
        tmoCnt      <= '0;
        lastWasData <= 1'b0;
      end else if (inAccess) begin
        if (mem_ack) begin
          if (stateQ == DATA) begin
            d_ready     <= 1'b1;
            d_rdata     <= mem_rdata;
            lastWasData <= 1'b1;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= fetchWord;
          end
        end else if (tmoExpire) begin
          // Abort: the owner still gets its completion pulse, with zeroed data.
          err <= 1'b1;
          if (stateQ == DATA) begin
            d_ready     <= 1'b1;
            d_rdata     <= '0;
            lastWasData <= 1'b1;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= '0;
          end
        end else begin
          tmoCnt <= tmoCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int N   = 64;
  localparam int W   = 32;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic [31:0]  if_rdata;
  logic         if_ready;
  logic         d_req;
  logic [1:0]   d_op;
  logic [W-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [N-1:0] d_rdata;
  logic         d_ready;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [7:0]   mem_be;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [7:0]   be;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    int           first;
    int           last;
    int           ackCyc;
  } acc_t;

  typedef struct {
    logic         isData;
    logic [N-1:0] data;
    int           cyc;
  } rdy_t;

  acc_t accs[$];
  rdy_t rdys[$];

  always #5 clk = ~clk;

  mem_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected lane enables and write data from the op-code rules.
  function automatic logic [7:0] refBe(input bit isD, input logic [1:0] op, input logic [2:0] off);
    if (isD && op == 2'b10) return 8'(1 << off);
    return 8'hFF;
  endfunction

  function automatic logic [N-1:0] refWdata(input logic [1:0] op, input logic [N-1:0] wd);
    logic [N-1:0] r;
    if (op == 2'b10) for (int k = 0; k < 8; k++) r[k*8 +: 8] = wd[7:0];
    else r = wd;
    return r;
  endfunction

  // Memory responder plus observer. Cycle 1 is the cycle after the edge that samples the requests.
  // Requesters drop their req in the cycle they see ready (data after dCount pulses).
  task automatic run_traffic(input int dCount, input bit randDly, input int fixDly,
                             input bit noAck, input bit useFixed, input logic [N-1:0] fixRdata);
    int   cyc = 0;
    int   dSeen = 0;
    int   waited = 0;
    int   dly = 0;
    int   tail = 0;
    bit   inAcc = 1'b0;
    acc_t a;
    rdy_t r;
    accs.delete();
    rdys.delete();
    while (tail < 3 && cyc < 80) begin
      step();
      cyc++;
      mem_ack = 1'b0;
      if (d_ready) begin
        r.isData = 1'b1; r.data = d_rdata; r.cyc = cyc;
        rdys.push_back(r);
        dSeen++;
        if (dSeen >= dCount) d_req = 1'b0;
      end
      if (if_ready) begin
        r.isData = 1'b0; r.data = {32'h0, if_rdata}; r.cyc = cyc;
        rdys.push_back(r);
        if_req = 1'b0;
      end
      if (mem_req) begin
        if (!inAcc) begin
          inAcc = 1'b1;
          waited = 0;
          dly = randDly ? int'($urandom_range(0, 3)) : fixDly;
          a.addr = mem_addr; a.we = mem_we; a.be = mem_be; a.wdata = mem_wdata;
          a.rdata = '0; a.first = cyc; a.ackCyc = -1;
        end
        a.last = cyc;
        if (!noAck && waited == dly) begin
          mem_ack = 1'b1;
          mem_rdata = useFixed ? fixRdata : {$urandom, $urandom};
          a.rdata = mem_rdata;
          a.ackCyc = cyc;
        end else begin
          waited++;
        end
      end else if (inAcc) begin
        inAcc = 1'b0;
        accs.push_back(a);
      end
      if (!d_req && !if_req && !mem_req) tail++;
      else tail = 0;
    end
    if (inAcc) accs.push_back(a);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_op = 2'b00;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset if_ready: got %b want 0", if_ready); end
    checks++; if (d_ready !== 1'b0)  begin errors++; $display("FAIL reset d_ready: got %b want 0", d_ready); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset if_rdata: got %h want 0", if_rdata); end
    checks++; if (d_rdata !== 64'h0) begin errors++; $display("FAIL reset d_rdata: got %h want 0", d_rdata); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset err: got %b want 0", err); end
    reset = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL idle mem_req: got %b want 0", mem_req); end
  endtask

  // Byte write, doubleword write at an unaligned address, reserved op as read.
  task automatic test_data_ops();
    logic [1:0]   ops[3];
    logic [W-1:0] addrs[3];
    logic [N-1:0] wds[3];
    int           dlys[3];
    logic [W-1:0] eAddr[3];
    logic [7:0]   eBe[3];
    logic         eWe[3];
    logic [N-1:0] eWd[3];
    ops   = '{2'b10, 2'b01, 2'b11};
    addrs = '{32'h0000_0103, 32'h0000_002F, 32'h0000_01E6};
    wds   = '{64'h0123_4567_89AB_CDA5, 64'hDEAD_BEEF_CAFE_F00D, 64'h5555_AAAA_5555_AAAA};
    dlys  = '{1, 0, 2};
    eAddr = '{32'h0000_0100, 32'h0000_0028, 32'h0000_01E0};
    eBe   = '{8'h08, 8'hFF, 8'hFF};
    eWe   = '{1'b1, 1'b1, 1'b0};
    eWd   = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_op = ops[i]; d_addr = addrs[i]; d_wdata = wds[i];
      run_traffic(1, 1'b0, dlys[i], 1'b0, 1'b0, '0);
      checks++;
      if (accs.size() != 1 || rdys.size() != 1) begin
        errors++;
        $display("FAIL dop[%0d] count: accesses=%0d readies=%0d want 1 and 1", i, accs.size(), rdys.size());
      end else begin
        checks++; if (accs[0].addr !== eAddr[i]) begin errors++; $display("FAIL dop[%0d] mem_addr: got %h want %h", i, accs[0].addr, eAddr[i]); end
        checks++; if (accs[0].be !== eBe[i])     begin errors++; $display("FAIL dop[%0d] mem_be: got %h want %h", i, accs[0].be, eBe[i]); end
        checks++; if (accs[0].we !== eWe[i])     begin errors++; $display("FAIL dop[%0d] mem_we: got %b want %b", i, accs[0].we, eWe[i]); end
        if (eWe[i]) begin
          checks++; if (accs[0].wdata !== eWd[i]) begin errors++; $display("FAIL dop[%0d] mem_wdata: got %h want %h", i, accs[0].wdata, eWd[i]); end
        end
        checks++; if (accs[0].first != 1) begin errors++; $display("FAIL dop[%0d] req cycle: got %0d want 1", i, accs[0].first); end
        checks++; if (rdys[0].isData !== 1'b1 || rdys[0].cyc != 2 + dlys[i]) begin
          errors++; $display("FAIL dop[%0d] d_ready: data=%b cycle=%0d want data=1 cycle=%0d", i, rdys[0].isData, rdys[0].cyc, 2 + dlys[i]);
        end
        checks++; if (d_rdata !== accs[0].rdata) begin errors++; $display("FAIL dop[%0d] d_rdata: got %h want %h", i, d_rdata, accs[0].rdata); end
      end
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0044;
    run_traffic(1, 1'b0, 2, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    checks++;
    if (accs.size() != 1 || rdys.size() != 1) begin
      errors++; $display("FAIL fetch count: accesses=%0d readies=%0d want 1 and 1", accs.size(), rdys.size());
    end else begin
      checks++; if (accs[0].addr !== 32'h40) begin errors++; $display("FAIL fetch mem_addr: got %h want 00000040", accs[0].addr); end
      checks++; if (accs[0].we !== 1'b0 || accs[0].be !== 8'hFF) begin errors++; $display("FAIL fetch we/be: got %b/%h want 0/ff", accs[0].we, accs[0].be); end
      checks++; if (rdys[0].isData !== 1'b0 || rdys[0].cyc != 4) begin errors++; $display("FAIL fetch if_ready: data=%b cycle=%0d want data=0 cycle=4", rdys[0].isData, rdys[0].cyc); end
      checks++; if (rdys[0].data[31:0] !== 32'h1111_2222) begin errors++; $display("FAIL fetch if_rdata: got %h want 11112222", rdys[0].data[31:0]); end
    end
    checks++; if (if_rdata !== 32'h1111_2222) begin errors++; $display("FAIL fetch hold: got %h want 11112222", if_rdata); end
  endtask

  task automatic test_priority();
    logic [N-1:0] half;
    d_req = 1'b1; d_op = 2'b00; d_addr = $urandom; if_req = 1'b1; if_addr = $urandom;
    run_traffic(1, 1'b1, 0, 1'b0, 1'b0, '0);
    checks++;
    if (accs.size() != 2 || rdys.size() != 2) begin
      errors++; $display("FAIL prio count: accesses=%0d readies=%0d want 2 and 2", accs.size(), rdys.size());
    end else begin
      checks++; if (rdys[0].isData !== 1'b1 || rdys[1].isData !== 1'b0) begin errors++; $display("FAIL prio order: got %b%b want 10", rdys[0].isData, rdys[1].isData); end
      checks++; if (accs[0].addr !== (d_addr & 32'hFFFF_FFF8)) begin errors++; $display("FAIL prio first addr: got %h want %h", accs[0].addr, d_addr & 32'hFFFF_FFF8); end
      checks++; if (accs[1].addr !== (if_addr & 32'hFFFF_FFF8)) begin errors++; $display("FAIL prio second addr: got %h want %h", accs[1].addr, if_addr & 32'hFFFF_FFF8); end
      checks++; if (rdys[0].data !== accs[0].rdata) begin errors++; $display("FAIL prio d_rdata: got %h want %h", rdys[0].data, accs[0].rdata); end
      half = {32'h0, if_addr[2] ? accs[1].rdata[63:32] : accs[1].rdata[31:0]};
      checks++; if (rdys[1].data !== half) begin errors++; $display("FAIL prio if_rdata: got %h want %h", rdys[1].data, half); end
      checks++; if (d_rdata !== accs[0].rdata) begin errors++; $display("FAIL prio d_rdata hold: got %h want %h", d_rdata, accs[0].rdata); end
    end
  endtask

  task automatic test_back_to_back();
    d_req = 1'b1; d_op = 2'b00; d_addr = $urandom; if_req = 1'b1; if_addr = $urandom;
    run_traffic(2, 1'b1, 0, 1'b0, 1'b0, '0);
    checks++;
    if (accs.size() != 3 || rdys.size() != 3) begin
      errors++; $display("FAIL b2b count: accesses=%0d readies=%0d want 3 and 3", accs.size(), rdys.size());
    end else begin
      checks++; if ({rdys[0].isData, rdys[1].isData, rdys[2].isData} !== 3'b101) begin
        errors++; $display("FAIL b2b order: got %b%b%b want 101", rdys[0].isData, rdys[1].isData, rdys[2].isData);
      end
      checks++; if (accs[1].addr !== (if_addr & 32'hFFFF_FFF8)) begin errors++; $display("FAIL b2b fetch addr: got %h want %h", accs[1].addr, if_addr & 32'hFFFF_FFF8); end
      checks++; if (accs[1].first != rdys[0].cyc + 1) begin errors++; $display("FAIL b2b fetch grant: req cycle %0d want %0d", accs[1].first, rdys[0].cyc + 1); end
    end
  endtask

  task automatic test_random();
    bit           prevData = 1'b1;
    bit           expOrder[$];
    bit           isD;
    int           kind;
    logic [1:0]   op;
    logic [W-1:0] da, ia, eAddr;
    logic [N-1:0] wd, eData;
    logic [7:0]   eBe;
    logic         eWe;
    for (int t = 0; t < 25; t++) begin
      kind = int'($urandom_range(0, 2));
      op = 2'($urandom_range(0, 3));
      da = $urandom; ia = $urandom; wd = {$urandom, $urandom};
      expOrder.delete();
      if (kind == 0) expOrder.push_back(1'b1);
      else if (kind == 1) expOrder.push_back(1'b0);
      else if (prevData) begin expOrder.push_back(1'b0); expOrder.push_back(1'b1); end
      else begin expOrder.push_back(1'b1); expOrder.push_back(1'b0); end
      d_req = (kind != 1); if_req = (kind != 0);
      d_op = op; d_addr = da; d_wdata = wd; if_addr = ia;
      run_traffic(1, 1'b1, 0, 1'b0, 1'b0, '0);
      checks++;
      if (accs.size() != expOrder.size() || rdys.size() != expOrder.size()) begin
        errors++; $display("FAIL rand[%0d] count: accesses=%0d readies=%0d want %0d", t, accs.size(), rdys.size(), expOrder.size());
      end else begin
        for (int i = 0; i < expOrder.size(); i++) begin
          isD   = expOrder[i];
          eAddr = (isD ? da : ia) & 32'hFFFF_FFF8;
          eWe   = isD && (op == 2'b01 || op == 2'b10);
          eBe   = refBe(isD, op, da[2:0]);
          eData = isD ? accs[i].rdata : {32'h0, ia[2] ? accs[i].rdata[63:32] : accs[i].rdata[31:0]};
          checks++; if (accs[i].addr !== eAddr) begin errors++; $display("FAIL rand[%0d.%0d] mem_addr: got %h want %h", t, i, accs[i].addr, eAddr); end
          checks++; if (accs[i].we !== eWe) begin errors++; $display("FAIL rand[%0d.%0d] mem_we: got %b want %b", t, i, accs[i].we, eWe); end
          checks++; if (accs[i].be !== eBe) begin errors++; $display("FAIL rand[%0d.%0d] mem_be: got %h want %h", t, i, accs[i].be, eBe); end
          if (eWe) begin
            checks++; if (accs[i].wdata !== refWdata(op, wd)) begin errors++; $display("FAIL rand[%0d.%0d] mem_wdata: got %h want %h", t, i, accs[i].wdata, refWdata(op, wd)); end
          end
          checks++; if (rdys[i].isData !== isD || rdys[i].cyc != accs[i].ackCyc + 1) begin
            errors++; $display("FAIL rand[%0d.%0d] ready: data=%b cycle=%0d want data=%b cycle=%0d", t, i, rdys[i].isData, rdys[i].cyc, isD, accs[i].ackCyc + 1);
          end
          checks++; if (rdys[i].data !== eData) begin errors++; $display("FAIL rand[%0d.%0d] rdata: got %h want %h", t, i, rdys[i].data, eData); end
        end
      end
      prevData = expOrder[expOrder.size() - 1];
    end
  endtask

  task automatic test_timeout();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo pre err: got %b want 0", err); end
    d_req = 1'b1; d_op = 2'b00; d_addr = $urandom;
    run_traffic(1, 1'b0, 0, 1'b1, 1'b0, '0);
    checks++;
    if (accs.size() != 1 || rdys.size() != 1) begin
      errors++; $display("FAIL tmo count: accesses=%0d readies=%0d want 1 and 1", accs.size(), rdys.size());
    end else begin
      checks++; if (accs[0].last - accs[0].first + 1 != TMO) begin errors++; $display("FAIL tmo wait: got %0d cycles want %0d", accs[0].last - accs[0].first + 1, TMO); end
      checks++; if (rdys[0].isData !== 1'b1 || rdys[0].cyc != accs[0].first + TMO) begin
        errors++; $display("FAIL tmo d_ready: data=%b cycle=%0d want data=1 cycle=%0d", rdys[0].isData, rdys[0].cyc, accs[0].first + TMO);
      end
      checks++; if (rdys[0].data !== 64'h0) begin errors++; $display("FAIL tmo d_rdata: got %h want 0", rdys[0].data); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo err: got %b want 1", err); end
    if_req = 1'b1; if_addr = $urandom;
    run_traffic(1, 1'b0, 1, 1'b0, 1'b0, '0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo err sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    d_req = 1'b1; d_op = 2'b00; d_addr = 32'h0000_0200;
    step();
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid in access: mem_req=%b busy=%b want 1 1", mem_req, busy); end
    reset = 1'b0; d_req = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid after reset: mem_req=%b busy=%b want 0 0", mem_req, busy); end
    if (d_ready || if_ready) pulses++;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
    for (int c = 0; c < 4; c++) begin
      step();
      mem_ack = 1'b0;
      if (d_ready || if_ready) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid ready pulses: got %0d want 0", pulses); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid late ack: mem_req=%b want 0", mem_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid err: got %b want 0", err); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 64'h0) begin errors++; $display("FAIL rstmid rdata: if=%h d=%h want 0 0", if_rdata, d_rdata); end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
